// File: rtl/pds_step_pipe_if.sv
// Handshake bundle for pds_step_pipe: operand/mode input channel, result output
// channel and buffer level. The master drives the beats, the slave is the pipe.
interface pds_step_pipe_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
);
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] data_ip;
   logic [1:0]        mode_ip;
   logic              valid_ip;
   logic              ready_ip;
   logic [DATA_W-1:0] data_op;
   logic              wrap_op;
   logic              valid_op;
   logic              ready_op;
   logic [LVL_W-1:0]  level_op;

   modport master (
      output data_ip, mode_ip, valid_ip, ready_op,
      input  ready_ip, data_op, wrap_op, valid_op, level_op
   );

   modport slave (
      input  data_ip, mode_ip, valid_ip, ready_op,
      output ready_ip, data_op, wrap_op, valid_op, level_op
   );
endinterface

// File: rtl/pds_step_pipe.sv
// Step arithmetic (add/sub/saturating add/pass) on accepted beats, results
// queued in a DEPTH-entry FIFO whose head is presented from registers.
module pds_step_pipe #(
   parameter int          DATA_W = 8,
   parameter int          DEPTH  = 4,
   parameter int unsigned STEP   = 1
) (
   input logic           clk,
   input logic           reset,
   pds_step_pipe_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [DATA_W:0]  STEP_X   = (DATA_W+1)'(STEP);
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   // Entry layout: {wrap, data}
   typedef logic [DATA_W:0] entry_t;

   entry_t            mem_q [DEPTH];
   entry_t            mem_d [DEPTH];
   logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              wrap_q, wrap_d;

   logic              push, pop;
   logic [DATA_W:0]   sum, diff;
   logic [DATA_W-1:0] res;
   logic              res_wrap;

   assign bus.ready_ip = (level_q < FULL_LVL);
   assign bus.valid_op = (level_q != '0);
   assign bus.level_op = level_q;
   assign bus.data_op  = data_q;
   assign bus.wrap_op  = wrap_q;

   assign push = bus.valid_ip && bus.ready_ip;
   assign pop  = bus.valid_op && bus.ready_op;

   always_comb begin
      sum      = {1'b0, bus.data_ip} + STEP_X;
      diff     = {1'b0, bus.data_ip} - STEP_X;
      res      = bus.data_ip;
      res_wrap = 1'b0;
      case (bus.mode_ip)
         2'b00: begin
            res      = sum[DATA_W-1:0];
            res_wrap = sum[DATA_W];
         end
         2'b01: begin
            res      = diff[DATA_W-1:0];
            res_wrap = diff[DATA_W];
         end
         2'b10: begin
            res      = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
            res_wrap = sum[DATA_W];
         end
         default: begin
            res      = bus.data_ip;
            res_wrap = 1'b0;
         end
      endcase
   end

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      data_d  = data_q;
      wrap_d  = wrap_q;
      if (push) begin
         mem_d[wptr_q] = {res_wrap, res};
         wptr_d        = wptr_q + PTR_W'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
      // Head register looks at the post-edge memory so a beat landing in an
      // empty buffer is visible right after its acceptance edge.
      if (level_d != '0) begin
         {wrap_d, data_d} = mem_d[rptr_d];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q   <= '{default: '0};
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         data_q  <= '0;
         wrap_q  <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         data_q  <= data_d;
         wrap_q  <= wrap_d;
      end
   end
endmodule

// File: doc/pds_step_pipe.md
PDS_STEP_PIPE -- requirements
Module: pds_step_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data path width in bits (range 1..32).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning output buffer entries (power of two, 2..16).
REQ-003 The block SHALL have parameter STEP, default 1, meaning arithmetic step magnitude (0 < STEP < 2^DATA_W).
REQ-004 Port list SHALL be:
- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high reset
- data_ip  input  DATA_W  input operand
- mode_ip  input  2  operation select, sampled with data_ip
- valid_ip  input  1  input beat present
- ready_ip  output  1  block can accept a beat
- data_op  output  DATA_W  result at buffer head
- wrap_op  output  1  head result wrapped or saturated
- valid_op  output  1  result present
- ready_op  input  1  downstream accepts result
- level_op  output  $clog2(DEPTH)+1  buffered entry count

Function
REQ-005 An input beat SHALL be accepted on a rising clk edge where valid_ip=1 and ready_ip=1; otherwise data_ip and mode_ip SHALL be ignored.
REQ-006 The result of an accepted beat SHALL be computed from data_ip and mode_ip as sampled at acceptance:
- 2'b00: data_ip+STEP modulo 2^DATA_W; wrap=1 iff carry out.
- 2'b01: data_ip-STEP modulo 2^DATA_W; wrap=1 iff borrow.
- 2'b10: min(data_ip+STEP, 2^DATA_W-1); wrap=1 iff clamped.
- 2'b11: data_ip unchanged; wrap=0.
REQ-007 Each result with its wrap bit SHALL be written into a FIFO of DEPTH entries in acceptance order.
REQ-008 A result SHALL be popped on a rising clk edge where valid_op=1 and ready_op=1.
REQ-009 valid_op SHALL equal 1 iff level_op>0; data_op and wrap_op SHALL present the oldest entry and be driven from registers.
REQ-010 Latency SHALL be exactly one cycle: a beat accepted at edge N into an empty buffer SHALL show valid_op=1 with its result after edge N.
REQ-011 ready_ip SHALL equal 1 iff level_op<DEPTH, with no combinational path from ready_op to ready_op-gated ready_ip (full SHALL block input even if a pop occurs that same edge).
REQ-012 Simultaneous accept and pop with 0<level_op<DEPTH SHALL leave level_op unchanged and preserve order.
REQ-013 Pop of the last entry without simultaneous accept SHALL deassert valid_op after that edge.
REQ-014 Read/write pointers SHALL wrap from DEPTH-1 to 0 with no loss or duplication.
REQ-015 While valid_op=1 and ready_op=0, data_op and wrap_op SHALL hold stable.
REQ-016 level_op SHALL be incremented on accept-only, decremented on pop-only, otherwise unchanged.

Reset
REQ-017 Asserting reset SHALL immediately, without a clock edge, force level_op=0, valid_op=0, ready_ip=1, data_op=0, wrap_op=0, pointers=0.
REQ-018 Reset asserted mid-operation SHALL discard all buffered entries; no beat SHALL be accepted or popped on an edge while reset=1.
REQ-019 After reset deassertion the first rising edge SHALL accept a valid beat normally.

Verification
REQ-020 DATA_W=8, STEP=1, mode 00, data_ip=8'h05, ready_op=1 -> next cycle data_op=8'h06, wrap_op=0, valid_op=1, then valid_op=0.
REQ-021 Mode 00 data 8'hFF -> 8'h00 wrap 1; mode 01 data 8'h00 -> 8'hFF wrap 1; mode 10 data 8'hFF -> 8'hFF wrap 1; mode 11 data 8'hA5 -> 8'hA5 wrap 0.
REQ-022 DEPTH=4, ready_op=0, five consecutive valid beats 1..5 -> four accepted, ready_ip=0 and level_op=4 after fourth; fifth held; raising ready_op drains 2,3,4,5 (mode 00) in order, then accepts the fifth beat.
REQ-023 Continuous valid_ip=1 and ready_op=1 for 20 beats -> one result per cycle, level_op steady at 1, pointers wrap, output sequence matches input+STEP.
REQ-024 Reset pulsed with level_op=3 -> valid_op=0, level_op=0, ready_ip=1 asynchronously; next beat after release emerges first.
REQ-025 STEP=3, DATA_W=4, mode 10 data 4'hE -> 4'hF wrap 1; mode 00 data 4'hE -> 4'h1 wrap 1.
